traffic_phase_controller: RTL and testbench
===========================================

Name: traffic_phase_controller

Overview:
- Downstream consumer of the four per-direction sensor averages (north/east/south/west, 8-bit each).
- Sequences the intersection through GREEN -> YELLOW -> ALL_RED per road, with green length scaled from that road's average.
- Drives next_road back to the sensors, so each sensor pushes a new sample when its road is announced as next.
- Round-robin order N(0) -> E(1) -> S(2) -> W(3), skipping empty roads.

Parameters:
- GREEN_MULT, 2, green cycles per unit of average.
- MIN_GREEN, 8, lower clamp on green length (cycles).
- MAX_GREEN, 200, upper clamp on green length (cycles).
- YELLOW_CYC, 4, yellow length (cycles).
- ALL_RED_CYC, 2, all-red clearance length (cycles).
- SKIP_THRESH, 1, roads with average below this are skipped.
- TW, 16, timer width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- avg_n, avg_e, avg_s, avg_w  in  8 each  sensor averages.
- next_road  out  2  road receiving green after the current one; feeds sensors.
- green_road  out  2  road currently owning the phase.
- light_n, light_e, light_s, light_w  out  2 each  0 = RED, 1 = YELLOW, 2 = GREEN.
- phase_timer  out  TW  cycles remaining in current phase, including this one.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n. All state is in registers clocked on the rising edge of clk.
- Reset (reset_n = 0, takes effect immediately, including mid-phase):
  - state = ALL_RED, phase_timer = ALL_RED_CYC.
  - all lights RED, green_road = 3, next_road = 0.
- States and transitions:
  - ALL_RED -> GREEN: when phase_timer == 1.
  - GREEN -> YELLOW: when phase_timer == 1.
  - YELLOW -> ALL_RED: when phase_timer == 1.
  - Otherwise phase_timer decrements by 1 each cycle, so a phase loaded with L lasts exactly L cycles.
- ALL_RED -> GREEN edge, all in one registered update:
  - green_road <= next_road.
  - Green length latched from that road's average sampled this cycle: L = clamp(avg * GREEN_MULT, MIN_GREEN, MAX_GREEN). Product is computed at TW bits with no overflow.
  - phase_timer <= L.
  - next_road <= successor of the new green_road: first road searched from green_road+1 mod 4 upward with avg >= SKIP_THRESH. The search excludes the new green road itself unless it is the only qualifying road. If no road qualifies, successor = green_road+1 mod 4.
  - Averages are sampled at this decision cycle only.
- GREEN -> YELLOW: phase_timer <= YELLOW_CYC; green_road's light goes YELLOW.
- YELLOW -> ALL_RED: phase_timer <= ALL_RED_CYC; all lights RED.
- Lights: only green_road's light is ever non-RED, and only in GREEN/YELLOW. Never two non-RED lights at once.
- Average changes during GREEN do not alter the latched length.
- next_road changes at most once per full rotation step; it is stable from one ALL_RED -> GREEN edge to the next.
- Only a single road qualifies: that road is green repeatedly, with a YELLOW and ALL_RED between consecutive greens.

Decomposition:
- Shared package: light encoding (RED/YELLOW/GREEN), road indices (NORTH..WEST), state enum (ALL_RED/GREEN/YELLOW).
- One sub-module: next_road_select, a combinational skip-aware round-robin picker (inputs: current road, four averages, threshold; output: 2-bit road).
- FSM, timer and clamp arithmetic stay in the top level.

Test Plan:
- All averages = 20, release reset:
  - 2 cycles all RED, then N GREEN for 40 cycles (next_road = 1 during that green).
  - Then N YELLOW 4 cycles, all RED 2 cycles, then E GREEN 40 cycles.
- Clamp: avg_n = 150 -> N green 200 cycles; avg_e = 2 -> E green 8 cycles.
- Skip: avg_e = 0, others 20 -> after N the next green is S; next_road = 2 throughout N green.
- All averages 0 -> pure round robin N, E, S, W, each green MIN_GREEN = 8 cycles.
- Only avg_w = 30, others 0 -> W green 60 cycles, YELLOW, ALL_RED, W green again. next_road stays 3.
- reset_n low at cycle 20 of N green -> all lights RED in the same cycle without waiting for clk. After release, sequence restarts from ALL_RED with next_road = 0. Changing avg_n mid-green leaves that green's length unchanged.

Source files
------------

// File: rtl/traffic_phase_controller_pkg.sv
// Shared encodings for the intersection phase controller:
// light codes, road indices and phase states.
package traffic_phase_controller_pkg;

    typedef enum logic [1:0] {
        L_RED    = 2'd0,
        L_YELLOW = 2'd1,
        L_GREEN  = 2'd2
    } light_t;

    typedef enum logic [1:0] {
        NORTH = 2'd0,
        EAST  = 2'd1,
        SOUTH = 2'd2,
        WEST  = 2'd3
    } road_t;

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2
    } state_t;

endpackage

// File: rtl/traffic_phase_controller_next_road_select.sv
// Skip-aware round-robin picker: first qualifying road after cur_road,
// falling back to cur_road itself, else plain cur_road+1.
module next_road_select
    import traffic_phase_controller_pkg::*;
(
    input  logic [1:0] cur_road,
    input  logic [7:0] avg_n,
    input  logic [7:0] avg_e,
    input  logic [7:0] avg_s,
    input  logic [7:0] avg_w,
    input  logic [7:0] thresh,
    output logic [1:0] next_road
);

    logic [3:0] qual;
    logic [1:0] cand;

    assign qual[NORTH] = (avg_n >= thresh);
    assign qual[EAST]  = (avg_e >= thresh);
    assign qual[SOUTH] = (avg_s >= thresh);
    assign qual[WEST]  = (avg_w >= thresh);

    // Walk from farthest to nearest so the nearest qualifying road wins;
    // k = 4 wraps to cur_road and is only kept if nothing else qualifies.
    always_comb begin
        next_road = cur_road + 2'd1;
        cand      = cur_road;
        for (int k = 4; k >= 1; k--) begin
            cand = cur_road + 2'(k);
            if (qual[cand]) next_road = cand;
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection sequencer: GREEN -> YELLOW -> ALL_RED per road, with the
// green length scaled from the sensor average latched at the decision edge.
module traffic_phase_controller
    import traffic_phase_controller_pkg::*;
#(
    parameter int GREEN_MULT  = 2,
    parameter int MIN_GREEN   = 8,
    parameter int MAX_GREEN   = 200,
    parameter int YELLOW_CYC  = 4,
    parameter int ALL_RED_CYC = 2,
    parameter int SKIP_THRESH = 1,
    parameter int TW          = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [7:0]    avg_n,
    input  logic [7:0]    avg_e,
    input  logic [7:0]    avg_s,
    input  logic [7:0]    avg_w,
    output logic [1:0]    next_road,
    output logic [1:0]    green_road,
    output logic [1:0]    light_n,
    output logic [1:0]    light_e,
    output logic [1:0]    light_s,
    output logic [1:0]    light_w,
    output logic [TW-1:0] phase_timer
);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer_nxt;
    logic [TW-1:0] prod;
    logic [TW-1:0] green_len;
    logic [7:0]    avg_sel;
    logic [1:0]    succ;
    logic          enter_green;
    light_t        active;

    // next_road is the road about to turn green, so the successor
    // is searched relative to it.
    next_road_select u_sel (
        .cur_road  (next_road),
        .avg_n     (avg_n),
        .avg_e     (avg_e),
        .avg_s     (avg_s),
        .avg_w     (avg_w),
        .thresh    (8'(SKIP_THRESH)),
        .next_road (succ)
    );

    always_comb begin
        unique case (road_t'(next_road))
            NORTH:   avg_sel = avg_n;
            EAST:    avg_sel = avg_e;
            SOUTH:   avg_sel = avg_s;
            default: avg_sel = avg_w;
        endcase
    end

    always_comb begin
        prod = TW'(avg_sel) * TW'(GREEN_MULT);
        if (prod < TW'(MIN_GREEN))
            green_len = TW'(MIN_GREEN);
        else if (prod > TW'(MAX_GREEN))
            green_len = TW'(MAX_GREEN);
        else
            green_len = prod;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_ALL_RED;
            phase_timer <= TW'(ALL_RED_CYC);
            green_road  <= WEST;
            next_road   <= NORTH;
        end else begin
            state       <= state_nxt;
            phase_timer <= timer_nxt;
            if (enter_green) begin
                green_road <= next_road;
                next_road  <= succ;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = phase_timer - TW'(1);
        enter_green = 1'b0;
        if (phase_timer == TW'(1)) begin
            unique case (state)
                S_ALL_RED: begin
                    state_nxt   = S_GREEN;
                    timer_nxt   = green_len;
                    enter_green = 1'b1;
                end
                S_GREEN: begin
                    state_nxt = S_YELLOW;
                    timer_nxt = TW'(YELLOW_CYC);
                end
                default: begin
                    state_nxt = S_ALL_RED;
                    timer_nxt = TW'(ALL_RED_CYC);
                end
            endcase
        end
    end

    always_comb begin
        active  = L_RED;
        if (state == S_GREEN)
            active = L_GREEN;
        else if (state == S_YELLOW)
            active = L_YELLOW;
        light_n = (green_road == NORTH) ? active : L_RED;
        light_e = (green_road == EAST)  ? active : L_RED;
        light_s = (green_road == SOUTH) ? active : L_RED;
        light_w = (green_road == WEST)  ? active : L_RED;
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: phase lengths, ordering,
// clamping, skipping, single-road repeat and asynchronous reset.
module tb_traffic_phase_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  avg_n;
    logic [7:0]  avg_e;
    logic [7:0]  avg_s;
    logic [7:0]  avg_w;
    logic [1:0]  next_road;
    logic [1:0]  green_road;
    logic [1:0]  light_n;
    logic [1:0]  light_e;
    logic [1:0]  light_s;
    logic [1:0]  light_w;
    logic [15:0] phase_timer;
    logic [7:0]  pat_now;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign pat_now = {light_n, light_e, light_s, light_w};

    traffic_phase_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .avg_n       (avg_n),
        .avg_e       (avg_e),
        .avg_s       (avg_s),
        .avg_w       (avg_w),
        .next_road   (next_road),
        .green_road  (green_road),
        .light_n     (light_n),
        .light_e     (light_e),
        .light_s     (light_s),
        .light_w     (light_w),
        .phase_timer (phase_timer)
    );

    // Counts cycles (sampled on negedge) the light pattern stays put.
    // Returns at the first negedge of the following phase.
    task automatic measure(output logic [7:0] pat, output int len,
                           output logic nr_ok);
        logic [1:0] nr;
        pat   = pat_now;
        nr    = next_road;
        nr_ok = 1'b1;
        len   = 0;
        while (pat_now == pat && len < 1000) begin
            if (next_road !== nr) nr_ok = 1'b0;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic set_avgs(input logic [7:0] n, input logic [7:0] e,
                            input logic [7:0] s, input logic [7:0] w);
        avg_n = n;
        avg_e = e;
        avg_s = s;
        avg_w = w;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (pat_now !== 8'h00) begin
            errors++;
            $display("FAIL reset_lights got=%h want=00", pat_now);
        end
        checks++;
        if (green_road !== 2'd3) begin
            errors++;
            $display("FAIL reset_green_road got=%0d want=3", green_road);
        end
        checks++;
        if (next_road !== 2'd0) begin
            errors++;
            $display("FAIL reset_next_road got=%0d want=0", next_road);
        end
        checks++;
        if (phase_timer !== 16'd2) begin
            errors++;
            $display("FAIL reset_timer got=%0d want=2", phase_timer);
        end
    endtask

    task automatic test_nominal();
        logic [7:0] p;
        int         l;
        logic       ok;
        set_avgs(8'd20, 8'd20, 8'd20, 8'd20);
        do_reset();
        measure(p, l, ok);
        checks++;
        if (p !== 8'h00 || l != 2) begin
            errors++;
            $display("FAIL nom_allred got=%h/%0d want=00/2", p, l);
        end
        checks++;
        if (green_road !== 2'd0 || phase_timer !== 16'd40) begin
            errors++;
            $display("FAIL nom_n_entry got=%0d/%0d want=0/40",
                     green_road, phase_timer);
        end
        checks++;
        if (next_road !== 2'd1) begin
            errors++;
            $display("FAIL nom_next got=%0d want=1", next_road);
        end
        measure(p, l, ok);
        checks++;
        if (p !== 8'h80 || l != 40 || !ok) begin
            errors++;
            $display("FAIL nom_n_green got=%h/%0d/%0b want=80/40/1", p, l, ok);
        end
        measure(p, l, ok);
        checks++;
        if (p !== 8'h40 || l != 4) begin
            errors++;
            $display("FAIL nom_n_yellow got=%h/%0d want=40/4", p, l);
        end
        measure(p, l, ok);
        checks++;
        if (p !== 8'h00 || l != 2) begin
            errors++;
            $display("FAIL nom_allred2 got=%h/%0d want=00/2", p, l);
        end
        measure(p, l, ok);
        checks++;
        if (p !== 8'h20 || l != 40) begin
            errors++;
            $display("FAIL nom_e_green got=%h/%0d want=20/40", p, l);
        end
    endtask

    task automatic test_clamp();
        logic [7:0] p;
        int         l;
        logic       ok;
        set_avgs(8'd150, 8'd2, 8'd20, 8'd20);
        do_reset();
        measure(p, l, ok);
        checks++;
        if (phase_timer !== 16'd200) begin
            errors++;
            $display("FAIL clamp_max_timer got=%0d want=200", phase_timer);
        end
        measure(p, l, ok);
        checks++;
        if (p !== 8'h80 || l != 200) begin
            errors++;
            $display("FAIL clamp_max_len got=%h/%0d want=80/200", p, l);
        end
        measure(p, l, ok);
        measure(p, l, ok);
        checks++;
        if (phase_timer !== 16'd8) begin
            errors++;
            $display("FAIL clamp_min_timer got=%0d want=8", phase_timer);
        end
        measure(p, l, ok);
        checks++;
        if (p !== 8'h20 || l != 8) begin
            errors++;
            $display("FAIL clamp_min_len got=%h/%0d want=20/8", p, l);
        end
    endtask

    task automatic test_skip();
        logic [7:0] p;
        int         l;
        logic       ok;
        set_avgs(8'd20, 8'd0, 8'd20, 8'd20);
        do_reset();
        measure(p, l, ok);
        checks++;
        if (next_road !== 2'd2) begin
            errors++;
            $display("FAIL skip_next got=%0d want=2", next_road);
        end
        measure(p, l, ok);
        checks++;
        if (p !== 8'h80 || l != 40 || !ok) begin
            errors++;
            $display("FAIL skip_n_green got=%h/%0d/%0b want=80/40/1", p, l, ok);
        end
        measure(p, l, ok);
        measure(p, l, ok);
        measure(p, l, ok);
        checks++;
        if (p !== 8'h08 || l != 40) begin
            errors++;
            $display("FAIL skip_s_green got=%h/%0d want=08/40", p, l);
        end
    endtask

    task automatic test_all_zero();
        logic [7:0] p;
        int         l;
        logic       ok;
        logic [7:0] want;
        set_avgs(8'd0, 8'd0, 8'd0, 8'd0);
        do_reset();
        measure(p, l, ok);
        for (int r = 0; r < 4; r++) begin
            want = 8'h80 >> (2 * r);
            measure(p, l, ok);
            checks++;
            if (p !== want || l != 8) begin
                errors++;
                $display("FAIL rr_green%0d got=%h/%0d want=%h/8", r, p, l, want);
            end
            measure(p, l, ok);
            checks++;
            if (p !== (want >> 1) || l != 4) begin
                errors++;
                $display("FAIL rr_yellow%0d got=%h/%0d want=%h/4",
                         r, p, l, want >> 1);
            end
            measure(p, l, ok);
            checks++;
            if (p !== 8'h00 || l != 2) begin
                errors++;
                $display("FAIL rr_allred%0d got=%h/%0d want=00/2", r, p, l);
            end
        end
    endtask

    task automatic test_single_road();
        logic [7:0] p;
        int         l;
        logic       ok;
        set_avgs(8'd0, 8'd0, 8'd0, 8'd30);
        do_reset();
        measure(p, l, ok);
        // Reset hands the first green to north regardless of its average.
        measure(p, l, ok);
        checks++;
        if (p !== 8'h80 || l != 8) begin
            errors++;
            $display("FAIL single_first got=%h/%0d want=80/8", p, l);
        end
        measure(p, l, ok);
        measure(p, l, ok);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (next_road !== 2'd3) begin
                errors++;
                $display("FAIL single_next%0d got=%0d want=3", i, next_road);
            end
            measure(p, l, ok);
            checks++;
            if (p !== 8'h02 || l != 60 || !ok) begin
                errors++;
                $display("FAIL single_w_green%0d got=%h/%0d/%0b want=02/60/1",
                         i, p, l, ok);
            end
            measure(p, l, ok);
            checks++;
            if (p !== 8'h01 || l != 4) begin
                errors++;
                $display("FAIL single_yellow%0d got=%h/%0d want=01/4", i, p, l);
            end
            measure(p, l, ok);
            checks++;
            if (p !== 8'h00 || l != 2) begin
                errors++;
                $display("FAIL single_allred%0d got=%h/%0d want=00/2", i, p, l);
            end
        end
    endtask

    task automatic test_latched();
        logic [7:0] p;
        int         l;
        logic       ok;
        set_avgs(8'd20, 8'd20, 8'd20, 8'd20);
        do_reset();
        measure(p, l, ok);
        repeat (10) @(negedge clk);
        avg_n = 8'd100;
        measure(p, l, ok);
        checks++;
        if (p !== 8'h80 || l != 30) begin
            errors++;
            $display("FAIL latched_rest got=%h/%0d want=80/30", p, l);
        end
        avg_n = 8'd20;
    endtask

    task automatic test_async_reset();
        logic [7:0] p;
        int         l;
        logic       ok;
        set_avgs(8'd20, 8'd20, 8'd20, 8'd20);
        do_reset();
        measure(p, l, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (pat_now !== 8'h80) begin
            errors++;
            $display("FAIL async_pre got=%h want=80", pat_now);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (pat_now !== 8'h00 || green_road !== 2'd3) begin
            errors++;
            $display("FAIL async_lights got=%h/%0d want=00/3", pat_now, green_road);
        end
        checks++;
        if (next_road !== 2'd0 || phase_timer !== 16'd2) begin
            errors++;
            $display("FAIL async_state got=%0d/%0d want=0/2",
                     next_road, phase_timer);
        end
        @(negedge clk);
        reset_n = 1'b1;
        measure(p, l, ok);
        checks++;
        if (p !== 8'h00 || l != 2) begin
            errors++;
            $display("FAIL async_allred got=%h/%0d want=00/2", p, l);
        end
        measure(p, l, ok);
        checks++;
        if (p !== 8'h80 || l != 40) begin
            errors++;
            $display("FAIL async_restart got=%h/%0d want=80/40", p, l);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        set_avgs(8'd20, 8'd20, 8'd20, 8'd20);
        @(negedge clk);
        test_reset();
        test_nominal();
        test_clamp();
        test_skip();
        test_all_zero();
        test_single_road();
        test_latched();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
